// File: rtl/half_pkg.sv
// rtl/half_pkg.sv - shared half-precision constants and sequencer state encoding
package half_pkg;

  localparam int HALF_EXP_W = 5;
  localparam int HALF_MAN_W = 10;
  localparam int HALF_BIAS  = 15;

  localparam logic [15:0] HALF_POS_INF = 16'h7C00;
  localparam logic [15:0] HALF_MAX     = 16'h7BFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/half_multiply_seq_if.sv
// rtl/half_multiply_seq_if.sv - operand/result handshake bundle for the half multiplier
interface half_multiply_seq_if;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic [15:0] c;

  modport master (output in_valid, output a, output b,
                  input in_ready, input out_valid, input c);
  modport slave  (input in_valid, input a, input b,
                  output in_ready, output out_valid, output c);

endinterface

// File: rtl/shift_add_multiply.sv
// rtl/shift_add_multiply.sv - iterative unsigned shift-add multiplier, WIDTH cycles per product
module shift_add_multiply #(
  parameter int WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplr;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               busy;
  logic               last;

  assign last    = (cnt == CW'(WIDTH - 1));
  assign done    = busy & last;
  assign product = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      mcand <= {{WIDTH{1'b0}}, multiplicand};
      mplr  <= multiplier;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      // multiplicand walks left while the multiplier walks right
      if (mplr[0]) begin
        acc <= acc + mcand;
      end
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      if (last) begin
        cnt  <= '0;
        busy <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/half_multiply_seq.sv
// rtl/half_multiply_seq.sv - iterative half-precision multiplier (no subnormals, truncating)
module half_multiply_seq
  import half_pkg::*;
#(
  parameter int BIAS     = HALF_BIAS,
  parameter bit SATURATE = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  half_multiply_seq_if.slave bus
);

  localparam int MW = HALF_MAN_W + 1;

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic               mul_done;
  logic [2*MW-1:0]    prod;

  logic               sign_q;
  logic               zero_q;
  logic signed [6:0]  exp_q;
  logic signed [6:0]  exp_n;
  logic [HALF_MAN_W-1:0] man_n;
  logic [15:0]        c_n;
  logic [15:0]        c_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign bus.c  = c_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MULT;
      MULT:    if (mul_done) state_nxt = NORM;
      NORM:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q <= 1'b0;
      zero_q <= 1'b0;
      exp_q  <= '0;
    end else if (accept) begin
      sign_q <= bus.a[15] ^ bus.b[15];
      zero_q <= (bus.a[14:10] == '0) | (bus.b[14:10] == '0);
      exp_q  <= 7'({2'b00, bus.a[14:10]}) + 7'({2'b00, bus.b[14:10]}) - 7'(BIAS);
    end
  end

  shift_add_multiply #(.WIDTH(MW)) u_mul (
    .clk          (clk),
    .rst          (rst),
    .start        (accept),
    .multiplicand ({1'b1, bus.a[9:0]}),
    .multiplier   ({1'b1, bus.b[9:0]}),
    .done         (mul_done),
    .product      (prod)
  );

  // product of two 1.x mantissas lies in [1,4); bit 21 set means the 2.x range
  always_comb begin
    if (prod[2*MW-1]) begin
      man_n = HALF_MAN_W'(prod >> MW);
      exp_n = exp_q + 7'sd1;
    end else begin
      man_n = HALF_MAN_W'(prod >> (MW - 1));
      exp_n = exp_q;
    end
  end

  always_comb begin
    if (zero_q) begin
      c_n = {sign_q, 15'b0};
    end else if (exp_n <= 7'sd0) begin
      c_n = {sign_q, 15'b0};
    end else if (exp_n >= 7'sd31) begin
      c_n = SATURATE ? {sign_q, HALF_MAX[14:0]} : {sign_q, HALF_POS_INF[14:0]};
    end else begin
      c_n = {sign_q, exp_n[HALF_EXP_W-1:0], man_n};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= '0;
    end else if (state == NORM) begin
      c_q <= c_n;
    end
  end

endmodule

// File: tb/tb_half_multiply_seq.sv
// tb/tb_half_multiply_seq.sv - self-checking bench for half_multiply_seq (both overflow modes)
module tb_half_multiply_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  half_multiply_seq_if bus0 ();
  half_multiply_seq_if bus1 ();

  half_multiply_seq #(.BIAS(15), .SATURATE(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  half_multiply_seq #(.BIAS(15), .SATURATE(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c0;
    logic [15:0] c1;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // real-valued view: value = 1.m * 2^(e-15), truncated to 10 fraction bits
  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input bit sat);
    int ea, eb, e, p, man;
    logic s;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    if (ea == 0 || eb == 0) return {s, 15'h0000};
    p = (1024 + int'(a[9:0])) * (1024 + int'(b[9:0]));
    e = ea + eb - 15;
    if (p >= (1 << 21)) begin
      man = (p / 2048) % 1024;
      e   = e + 1;
    end else begin
      man = (p / 1024) % 1024;
    end
    if (e <= 0) return {s, 15'h0000};
    if (e >= 31) return sat ? {s, 15'h7BFF} : {s, 15'h7C00};
    return {s, 5'(e), 10'(man)};
  endfunction

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b);
    bus0.in_valid = v; bus0.a = a; bus0.b = b;
    bus1.in_valid = v; bus1.a = a; bus1.b = b;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus0.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  // lat = index of the rising edge (accept = edge 0) that samples out_valid high
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r0, output logic [15:0] r1,
                       output int lat, output bit ready_low, output bit same_time);
    r0 = 16'hxxxx; r1 = 16'hxxxx; lat = -1; ready_low = 1'b1; same_time = 1'b0;
    wait_idle();
    drive(1'b1, a, b);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, a, b);
    for (int k = 0; k < 30; k++) begin
      if (bus0.out_valid) begin
        lat = k + 1;
        r0 = bus0.c;
        r1 = bus1.c;
        same_time = bus1.out_valid;
        break;
      end
      if (bus0.in_ready) ready_low = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
    if (bus0.out_valid) ready_low = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r0, r1, ra, rb;
    int lat, outs, ovcount;
    bit rl, st;
    int acc_t[$];
    logic [15:0] q0[$], q1[$];

    vecs.push_back('{16'h4000, 16'h4200, 16'h4600, 16'h4600});
    vecs.push_back('{16'h3E00, 16'h3E00, 16'h4080, 16'h4080});
    vecs.push_back('{16'hC000, 16'h3800, 16'hBC00, 16'hBC00});
    vecs.push_back('{16'h0000, 16'h4000, 16'h0000, 16'h0000});
    vecs.push_back('{16'h8000, 16'h4000, 16'h8000, 16'h8000});
    vecs.push_back('{16'h0400, 16'h0400, 16'h0000, 16'h0000});
    vecs.push_back('{16'h7800, 16'h7800, 16'h7C00, 16'h7BFF});
    vecs.push_back('{16'hF800, 16'h7800, 16'hFC00, 16'hFBFF});
    vecs.push_back('{16'h4000, 16'h4000, 16'h4400, 16'h4400});
    vecs.push_back('{16'h7800, 16'h3C00, 16'h7800, 16'h7800});
    vecs.push_back('{16'h7800, 16'h4000, 16'h7C00, 16'h7BFF});
    vecs.push_back('{16'h0400, 16'h3C00, 16'h0400, 16'h0400});
    vecs.push_back('{16'h0400, 16'h3800, 16'h0000, 16'h0000});
    vecs.push_back('{16'h0600, 16'h3A00, 16'h0480, 16'h0480});

    rst = 1'b1;
    drive(1'b0, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    chk("reset_in_ready", {15'b0, bus0.in_ready}, 16'h0001);
    chk("reset_out_valid", {15'b0, bus0.out_valid}, 16'h0000);
    chk("reset_c", bus0.c, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].a, vecs[i].b, r0, r1, lat, rl, st);
      chk($sformatf("vec%0d_sat0", i), r0, vecs[i].c0);
      chk($sformatf("vec%0d_sat1", i), r1, vecs[i].c1);
      chk_int($sformatf("vec%0d_latency", i), lat, 13);
      if (i == 0) begin
        chk("vec0_ready_low_and_single_pulse", {15'b0, rl}, 16'h0001);
        chk("vec0_both_valid", {15'b0, st}, 16'h0001);
      end
    end

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 2 == 0) begin
        ra[14:13] = 2'b01;
        rb[14:13] = 2'($urandom_range(1, 2));
      end
      do_op(ra, rb, r0, r1, lat, rl, st);
      chk($sformatf("rand%0d_%h_%h_sat0", i, ra, rb), r0, ref_mul(ra, rb, 1'b0));
      chk($sformatf("rand%0d_%h_%h_sat1", i, ra, rb), r1, ref_mul(ra, rb, 1'b1));
      chk_int($sformatf("rand%0d_latency", i), lat, 13);
    end

    // in_valid held high with fresh operands each cycle
    wait_idle();
    outs = 0;
    for (int t = 0; t < 42; t++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      ra[14:13] = 2'b01;
      rb[14:13] = 2'b01;
      if (bus0.out_valid) begin
        outs++;
        if (q0.size() > 0) begin
          chk($sformatf("stream_out%0d_sat0", outs), bus0.c, q0.pop_front());
          chk($sformatf("stream_out%0d_sat1", outs), bus1.c, q1.pop_front());
        end
      end
      drive(1'b1, ra, rb);
      if (bus0.in_ready) begin
        acc_t.push_back(t);
        q0.push_back(ref_mul(ra, rb, 1'b0));
        q1.push_back(ref_mul(ra, rb, 1'b1));
      end
      @(posedge clk);
      @(negedge clk);
    end
    drive(1'b0, 16'h0000, 16'h0000);
    chk_int("stream_out_count", outs, 3);
    chk_int("stream_accept_count", acc_t.size(), 3);
    for (int i = 0; i < acc_t.size() && i < 3; i++) begin
      chk_int($sformatf("stream_accept%0d_edge", i), acc_t[i], 14 * i);
    end

    // reset during MULT aborts the operation
    wait_idle();
    drive(1'b1, 16'h4000, 16'h4200);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 16'h0000, 16'h0000);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", {15'b0, bus0.in_ready}, 16'h0001);
    chk("abort_c", bus0.c, 16'h0000);
    ovcount = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus0.out_valid || bus1.out_valid) ovcount++;
      @(negedge clk);
    end
    chk_int("abort_no_out_valid", ovcount, 0);
    do_op(16'h4000, 16'h4000, r0, r1, lat, rl, st);
    chk("after_abort_sat0", r0, 16'h4400);
    chk("after_abort_sat1", r1, 16'h4400);
    chk_int("after_abort_latency", lat, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
